mem_req_arbiter: RTL and testbench

//  Shares the single CPU-side memory port between the instruction-fetch and data (load/store) requesters.

---
 rtl/mem_req_arbiter.sv | 86 ++++++++
 tb/tb_mem_req_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares one memory port between fetch and data requesters, with an abort timeout on lost mem_ok
module mem_req_arbiter #(
  parameter bit DATA_PRIO = 1'b1,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_addr,
  input  logic        inst_req,
  output logic [31:0] inst_data,
  output logic        inst_ok,
  output logic        inst_err,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_din,
  input  logic        data_req,
  input  logic        data_wreq,
  input  logic [3:0]  data_wbyte,
  output logic [31:0] data_data,
  output logic        data_ok,
  output logic        data_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_req,
  output logic        mem_wreq,
  output logic [3:0]  mem_wbyte,
  input  logic [31:0] mem_data,
  input  logic        mem_ok
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, state_n;
  logic owner, last_grant, wreq_q, err_q, pick_data, timeout, busy, resp;
  logic [31:0] addr_q, din_q, rdata_q;
  logic [3:0] wbyte_q;
  logic [7:0] cnt;
  always_comb begin
    pick_data = data_req & (~inst_req | DATA_PRIO | ~last_grant);
    timeout = (TIMEOUT != 0) && (cnt == 8'(TIMEOUT - 1));
    state_n = state == IDLE ? ((inst_req | data_req) ? BUSY : IDLE)
            : state == BUSY ? ((mem_ok | timeout) ? RESP : BUSY)
            : IDLE;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      owner <= 1'b0;
      last_grant <= 1'b0;
      addr_q <= '0;
      din_q <= '0;
      wreq_q <= 1'b0;
      wbyte_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
      cnt <= '0;
    end else begin
      if (state == IDLE && (inst_req | data_req)) begin
        owner <= pick_data;
        addr_q <= pick_data ? data_addr : inst_addr;
        din_q <= pick_data ? data_din : '0;
        wreq_q <= pick_data & data_wreq;
        wbyte_q <= pick_data ? data_wbyte : '0;
        cnt <= '0;
      end
      if (state == BUSY) begin
        cnt <= cnt + {7'd0, cnt != 8'hFF};
        if (mem_ok | timeout) begin
          rdata_q <= mem_ok ? mem_data : '0;
          err_q <= ~mem_ok;
        end
      end
      if (state == RESP) last_grant <= owner;
    end
  end
  assign busy = state == BUSY;
  assign resp = state == RESP;
  assign mem_req = busy;
  assign mem_addr = busy ? addr_q : '0;
  assign mem_din = busy ? din_q : '0;
  assign mem_wreq = busy & wreq_q;
  assign mem_wbyte = busy ? wbyte_q : '0;
  assign inst_ok = resp & ~owner;
  assign inst_data = inst_ok ? rdata_q : '0;
  assign inst_err = inst_ok & err_q;
  assign data_ok = resp & owner;
  assign data_data = data_ok ? rdata_q : '0;
  assign data_err = data_ok & err_q;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: table vectors, corner sequences and random traffic against a transaction-level model
module tb_mem_req_arbiter;
  localparam logic [31:0] IA = 32'h0000_4000, DA = 32'h1FAF_F000, DIN = 32'hDEAD_BEEF;
  localparam logic [3:0] WB = 4'b0011;
  logic clk = 0, rst = 1, inst_req = 0, data_req = 0, data_wreq = 0, mem_ok = 0;
  logic [31:0] inst_addr = 0, data_addr = 0, data_din = 0, mem_data = 0;
  logic [3:0] data_wbyte = 0;
  logic [31:0] o_idata[2], o_ddata[2], o_maddr[2], o_mdin[2];
  logic o_iok[2], o_ierr[2], o_dok[2], o_derr[2], o_mreq[2], o_mwr[2];
  logic [3:0] o_mwb[2];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  for (genvar i = 0; i < 2; i++) begin : g_dut
    mem_req_arbiter #(.DATA_PRIO(i == 0), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .inst_addr(inst_addr), .inst_req(inst_req), .inst_data(o_idata[i]), .inst_ok(o_iok[i]), .inst_err(o_ierr[i]),
      .data_addr(data_addr), .data_din(data_din), .data_req(data_req), .data_wreq(data_wreq), .data_wbyte(data_wbyte),
      .data_data(o_ddata[i]), .data_ok(o_dok[i]), .data_err(o_derr[i]),
      .mem_addr(o_maddr[i]), .mem_din(o_mdin[i]), .mem_req(o_mreq[i]), .mem_wreq(o_mwr[i]), .mem_wbyte(o_mwb[i]),
      .mem_data(mem_data), .mem_ok(mem_ok)
    );
  end
  typedef struct {
    logic txn, resp, last, owner, wr, err;
    logic [31:0] addr, din, rdata;
    logic [3:0] wb;
    int age;
  } mdl_t;
  mdl_t m[2];
  typedef struct {
    logic [4:0] in;
    logic [31:0] md;
    logic [3:0] ex;
    logic [31:0] maddr, mdin, rd;
    logic [3:0] mwb;
  } vec_t;
  vec_t tbl[15];
  logic q0[$], q1[$];
  int n;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic mdl_step(input int k);
    logic d;
    if (rst) begin
      m[k] = '{default: 0};
      return;
    end
    if (m[k].resp) begin
      m[k].last = m[k].owner;
      m[k].resp = 0;
    end else if (m[k].txn) begin
      if (mem_ok || m[k].age == 7) begin
        m[k].rdata = mem_ok ? mem_data : 32'h0;
        m[k].err = !mem_ok;
        m[k].resp = 1;
        m[k].txn = 0;
      end else m[k].age++;
    end else if (inst_req || data_req) begin
      d = data_req && (!inst_req || k == 0 || !m[k].last);
      m[k].txn = 1;
      m[k].age = 0;
      m[k].owner = d;
      m[k].addr = d ? data_addr : inst_addr;
      m[k].din = d ? data_din : 32'h0;
      m[k].wr = d && data_wreq;
      m[k].wb = d ? data_wbyte : 4'h0;
    end
  endtask
  task automatic mdl_check(input int k);
    string s;
    logic io, dk;
    s = $sformatf("dut%0d", k);
    io = m[k].resp && !m[k].owner;
    dk = m[k].resp && m[k].owner;
    chk({s, " mem_req"}, 32'(o_mreq[k]), 32'(m[k].txn));
    chk({s, " mem_addr"}, o_maddr[k], m[k].txn ? m[k].addr : 32'h0);
    chk({s, " mem_din"}, o_mdin[k], m[k].txn ? m[k].din : 32'h0);
    chk({s, " mem_wreq"}, 32'(o_mwr[k]), 32'(m[k].txn && m[k].wr));
    chk({s, " mem_wbyte"}, 32'(o_mwb[k]), 32'(m[k].txn ? m[k].wb : 4'h0));
    chk({s, " inst_ok"}, 32'(o_iok[k]), 32'(io));
    chk({s, " inst_data"}, o_idata[k], io ? m[k].rdata : 32'h0);
    chk({s, " inst_err"}, 32'(o_ierr[k]), 32'(io && m[k].err));
    chk({s, " data_ok"}, 32'(o_dok[k]), 32'(dk));
    chk({s, " data_data"}, o_ddata[k], dk ? m[k].rdata : 32'h0);
    chk({s, " data_err"}, 32'(o_derr[k]), 32'(dk && m[k].err));
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
    mdl_step(0);
    mdl_step(1);
    mdl_check(0);
    mdl_check(1);
  endtask
  initial begin
    tbl[0]  = '{5'b10000, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h0, 4'h0};
    tbl[1]  = '{5'b00100, 32'h0, 4'b1000, DA, DIN, 32'h0, WB};
    tbl[2]  = '{5'b00100, 32'h0, 4'b1000, DA, DIN, 32'h0, WB};
    tbl[3]  = '{5'b00101, 32'h1234_5678, 4'b0001, 32'h0, 32'h0, 32'h1234_5678, 4'h0};
    tbl[4]  = '{5'b00000, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h0, 4'h0};
    tbl[5]  = '{5'b00001, 32'hFFFF_FFFF, 4'b0000, 32'h0, 32'h0, 32'h0, 4'h0};
    tbl[6]  = '{5'b01100, 32'h0, 4'b1000, DA, DIN, 32'h0, WB};
    tbl[7]  = '{5'b01101, 32'hA5A5_A5A5, 4'b0001, 32'h0, 32'h0, 32'hA5A5_A5A5, 4'h0};
    tbl[8]  = '{5'b01001, 32'hFFFF_FFFF, 4'b0000, 32'h0, 32'h0, 32'h0, 4'h0};
    tbl[9]  = '{5'b01000, 32'h0, 4'b1000, IA, 32'h0, 32'h0, 4'h0};
    tbl[10] = '{5'b01001, 32'h0BAD_F00D, 4'b0010, 32'h0, 32'h0, 32'h0BAD_F00D, 4'h0};
    tbl[11] = '{5'b00000, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h0, 4'h0};
    tbl[12] = '{5'b00110, 32'h0, 4'b1100, DA, DIN, 32'h0, WB};
    tbl[13] = '{5'b00111, 32'h5555_AAAA, 4'b0001, 32'h0, 32'h0, 32'h5555_AAAA, 4'h0};
    tbl[14] = '{5'b00000, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h0, 4'h0};
    inst_addr = IA;
    data_addr = DA;
    data_din = DIN;
    data_wbyte = WB;
    for (int i = 0; i < 15; i++) begin
      {rst, inst_req, data_req, data_wreq, mem_ok} = tbl[i].in;
      mem_data = tbl[i].md;
      cyc();
      chk($sformatf("tbl%0d mem_req", i), 32'(o_mreq[0]), 32'(tbl[i].ex[3]));
      chk($sformatf("tbl%0d mem_wreq", i), 32'(o_mwr[0]), 32'(tbl[i].ex[2]));
      chk($sformatf("tbl%0d inst_ok", i), 32'(o_iok[0]), 32'(tbl[i].ex[1]));
      chk($sformatf("tbl%0d data_ok", i), 32'(o_dok[0]), 32'(tbl[i].ex[0]));
      chk($sformatf("tbl%0d mem_addr", i), o_maddr[0], tbl[i].maddr);
      chk($sformatf("tbl%0d mem_din", i), o_mdin[0], tbl[i].mdin);
      chk($sformatf("tbl%0d mem_wbyte", i), 32'(o_mwb[0]), 32'(tbl[i].mwb));
      chk($sformatf("tbl%0d inst_data", i), o_idata[0], tbl[i].ex[1] ? tbl[i].rd : 32'h0);
      chk($sformatf("tbl%0d data_data", i), o_ddata[0], tbl[i].ex[0] ? tbl[i].rd : 32'h0);
    end
    data_req = 1;
    data_wreq = 1;
    cyc();
    data_din = 32'h0;
    cyc();
    chk("store din held", o_mdin[0], DIN);
    mem_ok = 1;
    mem_data = 32'h0000_0001;
    cyc();
    chk("store ok", 32'(o_dok[0]), 32'h1);
    data_req = 0;
    data_wreq = 0;
    mem_ok = 0;
    data_din = DIN;
    cyc();
    inst_req = 1;
    cyc();
    n = 0;
    while (o_mreq[0] && n < 20) begin
      n++;
      cyc();
    end
    chk("timeout busy cycles", n, 8);
    chk("timeout inst_ok", 32'(o_iok[0]), 32'h1);
    chk("timeout inst_err", 32'(o_ierr[0]), 32'h1);
    chk("timeout inst_data", o_idata[0], 32'h0);
    inst_req = 0;
    cyc();
    inst_req = 1;
    cyc();
    repeat (7) cyc();
    mem_ok = 1;
    mem_data = 32'hCAFE_F00D;
    cyc();
    chk("ok at timeout inst_ok", 32'(o_iok[0]), 32'h1);
    chk("ok at timeout inst_err", 32'(o_ierr[0]), 32'h0);
    chk("ok at timeout inst_data", o_idata[0], 32'hCAFE_F00D);
    mem_ok = 0;
    inst_req = 0;
    cyc();
    data_req = 1;
    cyc();
    cyc();
    rst = 1;
    data_req = 0;
    cyc();
    chk("reset mem_req", 32'(o_mreq[0]), 32'h0);
    rst = 0;
    mem_ok = 1;
    repeat (3) begin
      cyc();
      chk("after reset no ok", 32'({o_iok[0], o_dok[0], o_mreq[0]}), 32'h0);
    end
    mem_ok = 0;
    data_req = 1;
    cyc();
    chk("post reset mem_req", 32'(o_mreq[0]), 32'h1);
    mem_ok = 1;
    mem_data = 32'h0000_0077;
    cyc();
    chk("post reset data_ok", 32'(o_dok[0]), 32'h1);
    chk("post reset data_data", o_ddata[0], 32'h0000_0077);
    data_req = 0;
    mem_ok = 0;
    rst = 1;
    cyc();
    rst = 0;
    inst_req = 1;
    data_req = 1;
    mem_ok = 1;
    mem_data = 32'h0000_1111;
    for (int c = 0; c < 30 && q1.size() < 4; c++) begin
      cyc();
      if (o_iok[0] || o_dok[0]) q0.push_back(o_dok[0]);
      if (o_iok[1] || o_dok[1]) q1.push_back(o_dok[1]);
    end
    chk("rr grant count", q1.size(), 4);
    for (int j = 0; j < q1.size(); j++) begin
      chk($sformatf("rr grant %0d", j), 32'(q1[j]), 32'(j % 2 == 0));
      if (j < q0.size()) chk($sformatf("prio grant %0d", j), 32'(q0[j]), 32'h1);
    end
    inst_req = 0;
    data_req = 0;
    mem_ok = 0;
    cyc();
    for (int c = 0; c < 3000; c++) begin
      if (!inst_req || o_iok[0]) begin
        inst_req = 1'($urandom_range(0, 1));
        inst_addr = $urandom;
      end else if ($urandom_range(0, 31) == 0) inst_req = 0;
      if (!data_req || o_dok[0]) begin
        data_req = 1'($urandom_range(0, 1));
        data_addr = $urandom;
        data_wreq = 1'($urandom_range(0, 1));
        data_wbyte = 4'($urandom_range(0, 15));
      end else if ($urandom_range(0, 31) == 0) data_req = 0;
      data_din = $urandom;
      mem_ok = $urandom_range(0, 3) == 0;
      mem_data = $urandom;
      rst = $urandom_range(0, 199) == 0;
      cyc();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
